br_tag_alloc: RTL

Superscalar, parametrised branch tag allocator and mask tracker for the R10K core.
- Accepts up to DISP_W speculative branches per dispatch bundle and assigns each a one-hot tag from a pool of BR_MASK_W.
- Gives every slot the branch mask it inherits, including tags of older branches in the same bundle.
- Frees tags on correct resolution and restores the mask on misprediction.
- Emits registered clear and squash broadcasts for the RS, ROB and LSQ mask-update logic.
- Sits between ID/dispatch and the ROB branch-resolution interface.

---
 rtl/br_tag_alloc_pkg.sv | 21 ++
 rtl/br_tag_alloc_pick.sv | 39 +++
 rtl/br_tag_alloc.sv | 94 +++++++++
 3 files changed

// File: rtl/br_tag_alloc_pkg.sv
// Shared branch-mask definitions: tag pool width, dispatch width, mask type
// and the population-count helper used for free-tag accounting.
package sys_defs;

   localparam int BR_MASK_W = 5;
   localparam int DISP_W    = 2;
   localparam int CNT_W     = $clog2(BR_MASK_W + 1);

   typedef logic [BR_MASK_W-1:0] br_mask_t;

   // Callers zero-extend into the 32-bit argument so one helper serves every width
   function automatic int unsigned popCount(input logic [31:0] v);
      int unsigned n;
      n = 0;
      for (int i = 0; i < 32; i++) begin
         n += 32'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/br_tag_alloc_pick.sv
// Combinational tag picker: each dispatch slot in ascending order takes the
// lowest free tag still left after all earlier slots have taken theirs.
module br_tag_pick
   import sys_defs::*;
(
   input  br_mask_t                    i_avail,
   input  logic [DISP_W-1:0]           i_req,
   output logic [DISP_W*BR_MASK_W-1:0] o_tags,
   output logic                        o_fail
);

   br_mask_t w_remain;
   br_mask_t w_pick;

   // One priority encoder per slot, each fed the pool minus earlier picks
   always_comb begin
      w_remain = i_avail;
      w_pick   = '0;
      o_tags   = '0;
      o_fail   = 1'b0;
      for (int k = 0; k < DISP_W; k++) begin
         w_pick = '0;
         for (int b = BR_MASK_W - 1; b >= 0; b--) begin
            if (w_remain[b]) begin
               w_pick = br_mask_t'(1) << b;
            end
         end
         if (!i_req[k]) begin
            w_pick = '0;
         end
         if (i_req[k] && (w_remain == '0)) begin
            o_fail = 1'b1;
         end
         o_tags[k*BR_MASK_W +: BR_MASK_W] = w_pick;
         w_remain = w_remain & ~w_pick;
      end
   end

endmodule

// File: rtl/br_tag_alloc.sv
// Branch tag allocator and mask tracker: tags speculative branches per dispatch
// bundle, frees tags on correct resolution and restores the mask on recovery.
module br_tag_alloc
   import sys_defs::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic [DISP_W-1:0]           id_valid_i,
   input  logic [DISP_W-1:0]           id_spec_br_i,
   input  logic                        rob_br_pred_correct_i,
   input  logic                        rob_br_recovery_i,
   input  br_mask_t                    rob_br_tag_i,
   input  br_mask_t                    rob_br_mask_i,
   output logic [DISP_W*BR_MASK_W-1:0] bmg_slot_mask_o,
   output logic [DISP_W*BR_MASK_W-1:0] bmg_slot_tag_o,
   output br_mask_t                    bmg_br_mask_o,
   output logic                        bmg_stall_o,
   output logic [CNT_W-1:0]            bmg_free_cnt_o,
   output br_mask_t                    bmg_clear_mask_o,
   output br_mask_t                    bmg_squash_mask_o
);

   br_mask_t                    r_mask;
   br_mask_t                    r_clear;
   br_mask_t                    r_squash;
   logic [CNT_W-1:0]            r_free_cnt;

   br_mask_t                    w_freed;
   br_mask_t                    w_base;
   br_mask_t                    w_avail;
   br_mask_t                    w_run;
   br_mask_t                    w_tag;
   br_mask_t                    w_mask_nxt;
   br_mask_t                    w_free_map;
   logic [DISP_W-1:0]           w_req;
   logic [DISP_W*BR_MASK_W-1:0] w_pick_tags;
   logic                        w_pick_fail;
   logic                        w_alloc;

   // A correct resolution frees its tag in the same cycle, so it is bypassed into avail
   assign w_freed  = (rob_br_pred_correct_i && !rob_br_recovery_i) ? rob_br_tag_i : '0;
   assign w_base   = r_mask & ~w_freed;
   assign w_avail  = ~w_base;
   assign w_req    = id_valid_i & id_spec_br_i;

   br_tag_pick u_pick (
      .i_avail (w_avail),
      .i_req   (w_req),
      .o_tags  (w_pick_tags),
      .o_fail  (w_pick_fail)
   );

   assign bmg_stall_o = !rob_br_recovery_i &&
                        (popCount(32'(w_req)) > popCount(32'(w_avail)));
   assign w_alloc     = !rob_br_recovery_i && !w_pick_fail;

   // Each slot inherits the base mask plus tags handed to older slots in the bundle
   always_comb begin
      w_run           = w_base;
      w_tag           = '0;
      bmg_slot_mask_o = '0;
      bmg_slot_tag_o  = '0;
      for (int k = 0; k < DISP_W; k++) begin
         w_tag = w_alloc ? w_pick_tags[k*BR_MASK_W +: BR_MASK_W] : '0;
         bmg_slot_mask_o[k*BR_MASK_W +: BR_MASK_W] = w_run;
         bmg_slot_tag_o[k*BR_MASK_W +: BR_MASK_W]  = w_tag;
         w_run = w_run | w_tag;
      end
   end

   assign w_mask_nxt    = rob_br_recovery_i ? rob_br_mask_i : w_run;
   assign w_free_map    = ~w_mask_nxt;
   assign bmg_br_mask_o = w_mask_nxt;

   // Mask state plus one-cycle clear/squash broadcasts; reset beats everything
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mask     <= '0;
         r_clear    <= '0;
         r_squash   <= '0;
         r_free_cnt <= CNT_W'(BR_MASK_W);
      end else begin
         r_mask     <= w_mask_nxt;
         r_clear    <= w_freed;
         r_squash   <= rob_br_recovery_i ? (r_mask & ~rob_br_mask_i) : '0;
         r_free_cnt <= CNT_W'(popCount(32'(w_free_map)));
      end
   end

   assign bmg_free_cnt_o    = r_free_cnt;
   assign bmg_clear_mask_o  = r_clear;
   assign bmg_squash_mask_o = r_squash;

endmodule
